// File: rtl/writeback_regfile.sv
// Writeback stage and architectural register file for the RV32I core.
// Aligns and extends load data, picks the writeback value, commits it to
// x1..x31 and serves two combinational read ports with write-through bypass.
module writeback_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      wa_i,
  input  logic            we_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] dmemdata_i,
  input  logic [3:0]      LD_sel_i,
  input  logic [4:0]      ra1_i,
  input  logic [4:0]      ra2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            wb_we_o,
  output logic [4:0]      wb_wa_o
);

  // x0 has no storage; entries 1..NREG-1 only.
  logic [XLEN-1:0] r_regs [1:NREG-1];

  logic [1:0]      w_off;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load;

  assign w_off   = wdata_i[1:0];
  assign wb_we_o = we_i && (wa_i != 5'd0);
  assign wb_wa_o = wa_i;

  // Byte/halfword lane selection from the low address bits.
  always_comb begin
    w_byte = dmemdata_i[7:0];
    case (w_off)
      2'd0: w_byte = dmemdata_i[7:0];
      2'd1: w_byte = dmemdata_i[15:8];
      2'd2: w_byte = dmemdata_i[23:16];
      2'd3: w_byte = dmemdata_i[31:24];
      default: w_byte = dmemdata_i[7:0];
    endcase
    w_half = w_off[1] ? dmemdata_i[31:16] : dmemdata_i[15:0];
  end

  // Extension by funct3; undefined encodings fall back to the full word.
  always_comb begin
    w_load = dmemdata_i;
    case (LD_sel_i[2:0])
      3'b000: w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001: w_load = {{(XLEN-16){w_half[15]}}, w_half};
      3'b100: w_load = {{(XLEN-8){1'b0}}, w_byte};
      3'b101: w_load = {{(XLEN-16){1'b0}}, w_half};
      default: w_load = dmemdata_i;
    endcase
  end

  // Writeback value: load result when a load is retiring, else ALU result.
  always_comb begin
    wb_data_o = LD_sel_i[3] ? w_load : wdata_i;
  end

  // Register commit; reset clears every entry asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_we_o) begin
      r_regs[wa_i] <= wb_data_o;
    end
  end

  // Read port 1: x0 is zero, in-flight write bypasses the array.
  always_comb begin
    rd1_o = '0;
    if (ra1_i == 5'd0) begin
      rd1_o = '0;
    end else if (wb_we_o && (ra1_i == wa_i)) begin
      rd1_o = wb_data_o;
    end else begin
      rd1_o = r_regs[ra1_i];
    end
  end

  // Read port 2: same rules as port 1, fully independent.
  always_comb begin
    rd2_o = '0;
    if (ra2_i == 5'd0) begin
      rd2_o = '0;
    end else if (wb_we_o && (ra2_i == wa_i)) begin
      rd2_o = wb_data_o;
    end else begin
      rd2_o = r_regs[ra2_i];
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: expectations are queued as
// stimulus is applied and popped against the DUT outputs when sampled.
`timescale 1ns/100ps
module tb_writeback_regfile;

  logic        clk;
  logic        rst;
  logic [4:0]  wa_i;
  logic        we_i;
  logic [31:0] wdata_i;
  logic [31:0] dmemdata_i;
  logic [3:0]  LD_sel_i;
  logic [4:0]  ra1_i;
  logic [4:0]  ra2_i;
  logic [31:0] rd1_o;
  logic [31:0] rd2_o;
  logic [31:0] wb_data_o;
  logic        wb_we_o;
  logic [4:0]  wb_wa_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          sel;   // 0 rd1, 1 rd2, 2 wb_data, 3 wb_we, 4 wb_wa
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  writeback_regfile #(.XLEN(32), .NREG(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .wa_i       (wa_i),
    .we_i       (we_i),
    .wdata_i    (wdata_i),
    .dmemdata_i (dmemdata_i),
    .LD_sel_i   (LD_sel_i),
    .ra1_i      (ra1_i),
    .ra2_i      (ra2_i),
    .rd1_o      (rd1_o),
    .rd2_o      (rd2_o),
    .wb_data_o  (wb_data_o),
    .wb_we_o    (wb_we_o),
    .wb_wa_o    (wb_wa_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0: obs = rd1_o;
        1: obs = rd2_o;
        2: obs = wb_data_o;
        3: obs = {31'd0, wb_we_o};
        default: obs = {27'd0, wb_wa_o};
      endcase
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] dm, input logic [3:0] ld,
                       input logic [4:0] r1, input logic [4:0] r2);
    we_i = we; wa_i = wa; wdata_i = wd; dmemdata_i = dm; LD_sel_i = ld;
    ra1_i = r1; ra2_i = r2;
  endtask

  function automatic logic [31:0] fill_val(input int i);
    return 32'hC0DE_0000 | (i * 32'h0000_0111);
  endfunction

  typedef struct {
    string       tag;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] dm;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t ld_vecs[$];

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 5'd0, 5'd0);
    #2;
    push("rst_rd1", 0, 32'd0);
    push("rst_rd2", 1, 32'd0);
    push("rst_wbdata", 2, 32'd0);
    push("rst_wbwe", 3, 32'd0);
    push("rst_wbwa", 4, 32'd0);
    drain();

    @(negedge clk);
    rst = 1'b0;

    // Fill x1..x31.
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), fill_val(i), 32'd0, 4'd0, 5'd0, 5'd0);
      @(negedge clk);
    end
    drive(1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 5'd0, 5'd0);
    for (int i = 1; i < 32; i++) begin
      ra1_i = 5'(i);
      ra2_i = 5'(32 - i);
      push("fill_rd1", 0, fill_val(i));
      push("fill_rd2", 1, fill_val(32 - i));
      #1;
      drain();
    end

    // Asynchronous reset between edges: every index must read 0 at once.
    @(negedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ra1_i = 5'(i);
      ra2_i = 5'(i + 16);
      push("async_rst_rd1", 0, 32'd0);
      push("async_rst_rd2", 1, 32'd0);
      #0.1;
      drain();
    end
    @(negedge clk);
    rst = 1'b0;

    // ALU write with bypass, then registered readback.
    @(negedge clk);
    drive(1'b1, 5'd5, 32'h1234_5678, 32'd0, 4'd0, 5'd5, 5'd6);
    push("alu_bypass_rd1", 0, 32'h1234_5678);
    push("alu_rd2_other", 1, 32'd0);
    push("alu_wbwe", 3, 32'd1);
    push("alu_wbwa", 4, 32'd5);
    push("alu_wbdata", 2, 32'h1234_5678);
    #1; drain();
    @(negedge clk);
    drive(1'b0, 5'd5, 32'd0, 32'd0, 4'd0, 5'd5, 5'd5);
    push("alu_reg_rd1", 0, 32'h1234_5678);
    push("alu_reg_rd2", 1, 32'h1234_5678);
    push("alu_nowe", 3, 32'd0);
    #1; drain();

    // Writes to x0 are discarded.
    @(negedge clk);
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 32'd0, 4'd0, 5'd0, 5'd0);
    push("x0_wbwe_pre", 3, 32'd0);
    push("x0_rd1_pre", 0, 32'd0);
    push("x0_wbdata", 2, 32'hFFFF_FFFF);
    #1; drain();
    @(negedge clk);
    push("x0_wbwe_post", 3, 32'd0);
    push("x0_rd1_post", 0, 32'd0);
    #1; drain();

    // Load extraction table; each load also writes x9 and reads it back via bypass.
    ld_vecs.push_back('{"lb_off0",  3'b000, 2'd0, 32'h80F1_7F82, 32'hFFFF_FF82});
    ld_vecs.push_back('{"lb_off1",  3'b000, 2'd1, 32'h80F1_7F82, 32'h0000_007F});
    ld_vecs.push_back('{"lb_off2",  3'b000, 2'd2, 32'h80F1_7F82, 32'hFFFF_FFF1});
    ld_vecs.push_back('{"lb_off3",  3'b000, 2'd3, 32'h80F1_7F82, 32'hFFFF_FF80});
    ld_vecs.push_back('{"lbu_off3", 3'b100, 2'd3, 32'h80F1_7F82, 32'h0000_0080});
    ld_vecs.push_back('{"lbu_off0", 3'b100, 2'd0, 32'h80F1_7F82, 32'h0000_0082});
    ld_vecs.push_back('{"lh_off0",  3'b001, 2'd0, 32'h8001_F00F, 32'hFFFF_F00F});
    ld_vecs.push_back('{"lh_off2",  3'b001, 2'd2, 32'h8001_F00F, 32'hFFFF_8001});
    ld_vecs.push_back('{"lh_off1",  3'b001, 2'd1, 32'h8001_F00F, 32'hFFFF_F00F});
    ld_vecs.push_back('{"lhu_off3", 3'b101, 2'd3, 32'h8001_F00F, 32'h0000_8001});
    ld_vecs.push_back('{"lhu_off0", 3'b101, 2'd0, 32'h8001_F00F, 32'h0000_F00F});
    ld_vecs.push_back('{"lw_off2",  3'b010, 2'd2, 32'h8001_F00F, 32'h8001_F00F});
    ld_vecs.push_back('{"f3_111",   3'b111, 2'd1, 32'h8001_F00F, 32'h8001_F00F});
    ld_vecs.push_back('{"f3_011",   3'b011, 2'd3, 32'h8001_F00F, 32'h8001_F00F});
    foreach (ld_vecs[k]) begin
      @(negedge clk);
      drive(1'b1, 5'd9, {28'h0001_000, 2'b00, ld_vecs[k].off}, ld_vecs[k].dm,
            {1'b1, ld_vecs[k].f3}, 5'd5, 5'd9);
      push(ld_vecs[k].tag, 2, ld_vecs[k].exp);
      push({ld_vecs[k].tag, "_byp"}, 1, ld_vecs[k].exp);
      #1; drain();
    end
    // Load valid low: the address passes through, not the memory data.
    @(negedge clk);
    drive(1'b1, 5'd9, 32'h0001_0003, 32'h8001_F00F, 4'b0000, 5'd9, 5'd0);
    push("ld_invalid", 2, 32'h0001_0003);
    #1; drain();
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 5'd9, 5'd0);
    push("ld_commit_x9", 0, 32'h0001_0003);
    #1; drain();

    // Dual-port bypass over an existing value.
    drive(1'b1, 5'd7, 32'h0000_000A, 32'd0, 4'd0, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b1, 5'd7, 32'h0000_000B, 32'd0, 4'd0, 5'd7, 5'd7);
    push("dual_byp_rd1", 0, 32'h0000_000B);
    push("dual_byp_rd2", 1, 32'h0000_000B);
    #1; drain();
    we_i = 1'b0;
    push("dual_nobyp_rd1", 0, 32'h0000_000A);
    push("dual_nobyp_rd2", 1, 32'h0000_000A);
    #1; drain();

    // Write asserted while in reset is lost.
    @(negedge clk);
    drive(1'b1, 5'd12, 32'hDEAD_BEEF, 32'd0, 4'd0, 5'd0, 5'd0);
    rst = 1'b1;
    @(negedge clk);
    we_i = 1'b0;
    ra1_i = 5'd12;
    push("rst_write_lost", 0, 32'd0);
    #1; drain();
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
